// File: rtl/req_pkg.sv
// Shared types and default sizes for the req_issuer request master.
package req_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    RESP = 2'd2
  } req_state_e;

  localparam int AW_DEF      = 4;
  localparam int DW_DEF      = 4;
  localparam int TIMEOUT_DEF = 15;

endpackage

// File: rtl/req_timer.sv
// 8-bit wait counter with a terminal-count flag at TIMEOUT-1.
module req_timer #(
  parameter int TIMEOUT = 15
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       clr_i,
  input  logic       inc_i,
  output logic       tc_o
);

  localparam logic [7:0] TC_VAL = 8'(TIMEOUT - 1);

  logic [7:0] count_q;
  logic [7:0] count_d;

  // Saturates at the compare point so a long stall can never wrap past it.
  always_comb begin
    count_d = count_q;
    if (clr_i) begin
      count_d = '0;
    end else if (inc_i && (count_q != TC_VAL)) begin
      count_d = count_q + 8'd1;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign tc_o = (count_q == TC_VAL);

endmodule

// File: rtl/req_issuer.sv
// Single-outstanding valid/ready request master with timeout-to-error.
// Optional REQ_ISSUER_STATS_EN adds txn_count/err_count outputs.
module req_issuer
  import req_pkg::*;
#(
  parameter int DW      = DW_DEF,
  parameter int AW      = AW_DEF,
  parameter int TIMEOUT = TIMEOUT_DEF
) (
  input  logic          clock,
  input  logic          reset,
  input  logic          cmd_valid,
  output logic          cmd_ready,
  input  logic [AW-1:0] cmd_addr,
  input  logic [DW-1:0] cmd_wdata,
  output logic          bus_valid,
  output logic [AW-1:0] bus_addr,
  output logic [DW-1:0] bus_wdata,
  input  logic          bus_ready,
  input  logic [DW-1:0] bus_rdata,
  output logic          resp_valid,
  input  logic          resp_ready,
  output logic [DW-1:0] resp_rdata,
  output logic          resp_err
`ifdef REQ_ISSUER_STATS_EN
  ,
  output logic [7:0]    txn_count,
  output logic [7:0]    err_count
`endif
);

  req_state_e    state_q, state_d;
  logic [AW-1:0] bus_addr_q, bus_addr_d;
  logic [DW-1:0] bus_wdata_q, bus_wdata_d;
  logic [DW-1:0] resp_rdata_q, resp_rdata_d;
  logic          resp_err_q, resp_err_d;
  logic          tmr_clr, tmr_inc, tmr_tc;

  req_timer #(.TIMEOUT(TIMEOUT)) u_timer (
    .clock (clock),
    .reset (reset),
    .clr_i (tmr_clr),
    .inc_i (tmr_inc),
    .tc_o  (tmr_tc)
  );

  // bus_ready is checked before the timeout so a late completion still wins.
  always_comb begin
    state_d      = state_q;
    bus_addr_d   = bus_addr_q;
    bus_wdata_d  = bus_wdata_q;
    resp_rdata_d = resp_rdata_q;
    resp_err_d   = resp_err_q;
    tmr_clr      = 1'b0;
    tmr_inc      = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (cmd_valid) begin
          bus_addr_d  = cmd_addr;
          bus_wdata_d = cmd_wdata;
          tmr_clr     = 1'b1;
          state_d     = REQ;
        end
      end
      REQ: begin
        if (bus_ready) begin
          resp_rdata_d = bus_rdata;
          resp_err_d   = 1'b0;
          state_d      = RESP;
        end else if (tmr_tc) begin
          resp_rdata_d = '0;
          resp_err_d   = 1'b1;
          state_d      = RESP;
        end else begin
          tmr_inc = 1'b1;
        end
      end
      RESP: begin
        if (resp_ready) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q      <= IDLE;
      bus_addr_q   <= '0;
      bus_wdata_q  <= '0;
      resp_rdata_q <= '0;
      resp_err_q   <= 1'b0;
    end else begin
      state_q      <= state_d;
      bus_addr_q   <= bus_addr_d;
      bus_wdata_q  <= bus_wdata_d;
      resp_rdata_q <= resp_rdata_d;
      resp_err_q   <= resp_err_d;
    end
  end

  assign cmd_ready  = (state_q == IDLE);
  assign bus_valid  = (state_q == REQ);
  assign resp_valid = (state_q == RESP);
  assign bus_addr   = bus_addr_q;
  assign bus_wdata  = bus_wdata_q;
  assign resp_rdata = resp_rdata_q;
  assign resp_err   = resp_err_q;

`ifdef REQ_ISSUER_STATS_EN
  logic [7:0] txn_count_q, err_count_q;

  always_ff @(posedge clock) begin
    if (reset) begin
      txn_count_q <= '0;
      err_count_q <= '0;
    end else if ((state_q == RESP) && resp_ready) begin
      txn_count_q <= txn_count_q + 8'd1;
      err_count_q <= err_count_q + {7'd0, resp_err_q};
    end
  end

  assign txn_count = txn_count_q;
  assign err_count = err_count_q;
`endif

endmodule

// File: tb/tb_req_issuer.sv
// Directed self-checking bench for req_issuer (TIMEOUT=15).
module tb_req_issuer;

  logic       clock;
  logic       reset;
  logic       cmd_valid;
  logic       cmd_ready;
  logic [3:0] cmd_addr;
  logic [3:0] cmd_wdata;
  logic       bus_valid;
  logic [3:0] bus_addr;
  logic [3:0] bus_wdata;
  logic       bus_ready;
  logic [3:0] bus_rdata;
  logic       resp_valid;
  logic       resp_ready;
  logic [3:0] resp_rdata;
  logic       resp_err;
`ifdef REQ_ISSUER_STATS_EN
  logic [7:0] txn_count;
  logic [7:0] err_count;
`endif

  int errors = 0;
  int checks = 0;
  int nValid;

  req_issuer #(.DW(4), .AW(4), .TIMEOUT(15)) dut (
    .clock      (clock),
    .reset      (reset),
    .cmd_valid  (cmd_valid),
    .cmd_ready  (cmd_ready),
    .cmd_addr   (cmd_addr),
    .cmd_wdata  (cmd_wdata),
    .bus_valid  (bus_valid),
    .bus_addr   (bus_addr),
    .bus_wdata  (bus_wdata),
    .bus_ready  (bus_ready),
    .bus_rdata  (bus_rdata),
    .resp_valid (resp_valid),
    .resp_ready (resp_ready),
    .resp_rdata (resp_rdata),
    .resp_err   (resp_err)
`ifdef REQ_ISSUER_STATS_EN
    ,
    .txn_count  (txn_count),
    .err_count  (err_count)
`endif
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Advance one clock and settle just past the rising edge.
  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic checkOutput(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("[TB] FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic applyStimulus(input logic [3:0] a, input logic [3:0] d);
    cmd_valid = 1'b1;
    cmd_addr  = a;
    cmd_wdata = d;
    tick();
    cmd_valid = 1'b0;
  endtask

  // Complete one transaction; stuck=1 leaves the responder silent.
  task automatic runTxn(input logic [3:0] a, input logic [3:0] r, input bit stuck);
    applyStimulus(a, 4'h0);
    if (!stuck) begin
      bus_ready = 1'b1;
      bus_rdata = r;
      tick();
      bus_ready = 1'b0;
    end else begin
      for (int i = 0; i < 40 && bus_valid; i++) tick();
    end
    checkOutput("txn_resp_valid", {7'd0, resp_valid}, 8'd1);
    resp_ready = 1'b1;
    tick();
    resp_ready = 1'b0;
  endtask

  initial begin
    reset = 1'b1; cmd_valid = 1'b0; cmd_addr = '0; cmd_wdata = '0;
    bus_ready = 1'b0; bus_rdata = '0; resp_ready = 1'b0;
    tick();
    checkOutput("rst_cmd_ready",  {7'd0, cmd_ready},  8'd1);
    checkOutput("rst_bus_valid",  {7'd0, bus_valid},  8'd0);
    checkOutput("rst_resp_valid", {7'd0, resp_valid}, 8'd0);
    checkOutput("rst_resp_err",   {7'd0, resp_err},   8'd0);
    checkOutput("rst_bus_addr",   {4'd0, bus_addr},   8'h0);
    checkOutput("rst_resp_rdata", {4'd0, resp_rdata}, 8'h0);
    reset = 1'b0;

    // Normal transaction: ready at cycle 3, response at cycle 4.
    applyStimulus(4'ha, 4'h4);
    checkOutput("t1_bus_valid_c1", {7'd0, bus_valid}, 8'd1);
    checkOutput("t1_cmd_ready_c1", {7'd0, cmd_ready}, 8'd0);
    checkOutput("t1_bus_addr",     {4'd0, bus_addr},  8'ha);
    checkOutput("t1_bus_wdata",    {4'd0, bus_wdata}, 8'h4);
    tick();
    checkOutput("t1_bus_valid_c2", {7'd0, bus_valid}, 8'd1);
    tick();
    checkOutput("t1_bus_valid_c3", {7'd0, bus_valid}, 8'd1);
    bus_ready = 1'b1; bus_rdata = 4'h5;
    tick();
    bus_ready = 1'b0; bus_rdata = 4'h0;
    checkOutput("t1_bus_valid_c4",  {7'd0, bus_valid},  8'd0);
    checkOutput("t1_resp_valid",    {7'd0, resp_valid}, 8'd1);
    checkOutput("t1_resp_rdata",    {4'd0, resp_rdata}, 8'h5);
    checkOutput("t1_resp_err",      {7'd0, resp_err},   8'd0);
    resp_ready = 1'b1;
    tick();
    resp_ready = 1'b0;
    checkOutput("t1_idle_resp_valid", {7'd0, resp_valid}, 8'd0);
    checkOutput("t1_idle_cmd_ready",  {7'd0, cmd_ready},  8'd1);

    // bus_ready outside REQ must be ignored.
    bus_ready = 1'b1; bus_rdata = 4'hf;
    tick();
    bus_ready = 1'b0;
    checkOutput("idle_ready_ignored", {7'd0, resp_valid}, 8'd0);

    // Stuck responder: exactly 15 cycles of bus_valid then an error response.
    applyStimulus(4'h3, 4'h7);
    nValid = 0;
    for (int i = 0; i < 40 && bus_valid; i++) begin
      nValid++;
      tick();
    end
    checkOutput("to_valid_cycles", 8'(nValid), 8'd15);
    checkOutput("to_resp_valid", {7'd0, resp_valid}, 8'd1);
    checkOutput("to_resp_err",   {7'd0, resp_err},   8'd1);
    checkOutput("to_resp_rdata", {4'd0, resp_rdata}, 8'h0);
    resp_ready = 1'b1;
    tick();
    resp_ready = 1'b0;

    // bus_ready on the 15th REQ cycle (timeout boundary) wins.
    applyStimulus(4'h2, 4'h1);
    for (int i = 0; i < 14; i++) tick();
    checkOutput("bnd_bus_valid_c15", {7'd0, bus_valid}, 8'd1);
    bus_ready = 1'b1; bus_rdata = 4'h9;
    tick();
    bus_ready = 1'b0;
    checkOutput("bnd_resp_valid", {7'd0, resp_valid}, 8'd1);
    checkOutput("bnd_resp_err",   {7'd0, resp_err},   8'd0);
    checkOutput("bnd_resp_rdata", {4'd0, resp_rdata}, 8'h9);

    // Consumer backpressure for 5 cycles.
    for (int i = 0; i < 5; i++) begin
      tick();
      checkOutput("bp_resp_valid", {7'd0, resp_valid}, 8'd1);
      checkOutput("bp_resp_rdata", {4'd0, resp_rdata}, 8'h9);
      checkOutput("bp_cmd_ready",  {7'd0, cmd_ready},  8'd0);
    end
    resp_ready = 1'b1;
    tick();
    resp_ready = 1'b0;
    checkOutput("bp_release_cmd_ready",  {7'd0, cmd_ready},  8'd1);
    checkOutput("bp_release_resp_valid", {7'd0, resp_valid}, 8'd0);

    // Reset in the middle of a request aborts it.
    applyStimulus(4'h8, 4'h2);
    tick();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    checkOutput("mid_rst_bus_valid",  {7'd0, bus_valid},  8'd0);
    checkOutput("mid_rst_resp_valid", {7'd0, resp_valid}, 8'd0);
    checkOutput("mid_rst_cmd_ready",  {7'd0, cmd_ready},  8'd1);
    checkOutput("mid_rst_bus_addr",   {4'd0, bus_addr},   8'h0);
    tick();
    checkOutput("mid_rst_no_resp", {7'd0, resp_valid}, 8'd0);
`ifdef REQ_ISSUER_STATS_EN
    checkOutput("stats_rst_txn", txn_count, 8'd0);
    checkOutput("stats_rst_err", err_count, 8'd0);
`endif
    applyStimulus(4'h6, 4'h1);
    checkOutput("post_rst_bus_valid", {7'd0, bus_valid}, 8'd1);
    checkOutput("post_rst_bus_addr",  {4'd0, bus_addr},  8'h6);
    bus_ready = 1'b1; bus_rdata = 4'hc;
    tick();
    bus_ready = 1'b0;
    checkOutput("post_rst_resp_rdata", {4'd0, resp_rdata}, 8'hc);
    resp_ready = 1'b1;
    tick();
    resp_ready = 1'b0;

    runTxn(4'h1, 4'h3, 1'b0);
    runTxn(4'h4, 4'h0, 1'b1);
    runTxn(4'h5, 4'h7, 1'b0);
    checkOutput("final_cmd_ready", {7'd0, cmd_ready}, 8'd1);
`ifdef REQ_ISSUER_STATS_EN
    checkOutput("stats_txn", txn_count, 8'd4);
    checkOutput("stats_err", err_count, 8'd1);
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/req_issuer.md
Name: req_issuer

Overview:
- Single-outstanding request master sitting directly upstream of the valid/ready responder stage, which has 4-bit addr/wdata/rdata.
- Accepts commands from a producer over a valid/ready handshake and drives the responder's valid line.
- Waits for the responder's ready, captures its 4-bit rdata and returns the result through a response handshake.
- A bounded wait counter converts a stuck responder into an error response.

Parameters:
- DW, 4, data width of wdata/rdata.
- AW, 4, address width.
- TIMEOUT, 15, max cycles bus_valid stays high without bus_ready before an error response; legal range 1..255.

Ports:
- clock  in  1  single clock, rising edge.
- reset  in  1  synchronous, active-high.
- cmd_valid  in  1  producer has a command.
- cmd_ready  out  1  issuer can accept a command.
- cmd_addr  in  AW  command address.
- cmd_wdata  in  DW  command write data.
- bus_valid  out  1  request valid to the responder.
- bus_addr  out  AW  registered address to the responder.
- bus_wdata  out  DW  registered write data to the responder.
- bus_ready  in  1  responder completes the request.
- bus_rdata  in  DW  responder read data, valid when bus_ready=1.
- resp_valid  out  1  response available.
- resp_ready  in  1  consumer takes the response.
- resp_rdata  out  DW  captured read data.
- resp_err  out  1  response produced by timeout.

Behaviour:
- Interface: one clock; reset is synchronous and active-high.
- Reset values:
  - state=IDLE.
  - cmd_ready=1, bus_valid=0, resp_valid=0, resp_err=0.
  - bus_addr=0, bus_wdata=0, resp_rdata=0, wait counter=0.
- IDLE:
  - cmd_ready=1.
  - On cmd_valid&cmd_ready, register cmd_addr/cmd_wdata into bus_addr/bus_wdata, clear the counter, go REQ.
  - bus_valid rises the cycle after acceptance (latency 1).
- REQ:
  - bus_valid=1, cmd_ready=0.
  - bus_addr/bus_wdata are held stable until completion.
  - If bus_ready=1: capture bus_rdata into resp_rdata, resp_err=0, go RESP; bus_valid drops next cycle.
  - Else if counter==TIMEOUT-1: resp_rdata=0, resp_err=1, go RESP.
  - Else: counter+1.
  - bus_ready in the same cycle as the timeout boundary wins (normal response, no error).
- RESP:
  - resp_valid=1; resp_rdata/resp_err held stable.
  - On resp_ready=1, go IDLE; resp_valid drops next cycle.
- No back-to-back bypass; minimum command-to-command spacing is 3 cycles (accept, request, response with immediate resp_ready).
- bus_ready while not in REQ is ignored.
- cmd_valid while cmd_ready=0 is ignored; the producer must hold it.
- Counter is 8 bits and never wraps: it is cleared on entry to REQ and saturates at its compare point.
- Reset mid-operation aborts any request immediately: outputs return to reset values on the next edge and no response is issued.
- All outputs are registered or decoded directly from state; there is no combinational path from bus_ready to cmd_ready.

Optional Feature:
- Macro REQ_ISSUER_STATS_EN.
- When defined, two extra outputs are added:
  - txn_count (8 bits): increments on every RESP→IDLE handoff.
  - err_count (8 bits): increments on handoffs with resp_err=1.
  - Both wrap modulo 256 and reset to 0.
- When undefined, these ports and their registers are absent; all other behaviour is identical.

Decomposition:
- Shared package req_pkg holds:
  - state enum {IDLE=2'd0, REQ=2'd1, RESP=2'd2};
  - default widths AW_DEF=4, DW_DEF=4;
  - TIMEOUT_DEF=15.
- One sub-module, req_timer: 8-bit clear/increment counter with a terminal-count flag compared against TIMEOUT-1.
- The FSM and datapath stay in req_issuer.

Test Plan:
- Reset → cmd_ready=1, bus_valid=0, resp_valid=0, resp_err=0 after one edge with reset high.
- cmd addr=4'ha wdata=4'h4 at cycle 0; responder asserts bus_ready with rdata=4'h5 at cycle 3 → bus_valid high cycles 1–3, bus_addr=4'ha, resp_valid at cycle 4 with rdata=4'h5, err=0.
- Responder stuck low, TIMEOUT=15 → bus_valid high for exactly 15 cycles, then resp_valid=1, resp_err=1, resp_rdata=0.
- bus_ready arrives in the same cycle as the timeout boundary → resp_err=0, rdata captured.
- Completed response with resp_ready held low 5 cycles → resp_valid/resp_rdata stable for all 5 cycles; cmd_ready stays 0 until the cycle after resp_ready.
- Reset asserted mid-REQ → bus_valid=0 next cycle, no resp_valid; a new command is accepted afterwards. With REQ_ISSUER_STATS_EN, 3 normal transactions plus 1 timeout → txn_count=4, err_count=1.
